// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with write-through bypass and per-register busy scoreboard.
// Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero and never mark it busy.
module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wrt_en,
    input  logic [ADDR_W-1:0]          wrt_addr,
    input  logic [DATA_W-1:0]          wrt_data,
    input  logic                       issue_en,
    input  logic [ADDR_W-1:0]          issue_addr,
    output logic [ADDR_W:0]            busy_cnt
);
    localparam int DEPTH = 1 << ADDR_W;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy, busy_nxt;
    logic [ADDR_W:0]   cnt_nxt;
    logic              wr_ok, iss_ok;

    assign wr_ok  = wrt_en && !(ZERO_REG && wrt_addr == '0);
    assign iss_ok = issue_en && !(ZERO_REG && issue_addr == '0);

    // set is applied after clear so a new producer supersedes the completing one
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) busy_nxt[wrt_addr] = 1'b0;
        if (iss_ok) busy_nxt[issue_addr] = 1'b1;
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wr_ok) regs[wrt_addr] <= wrt_data;
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              byp;
        assign ra  = rd_addr[g*ADDR_W +: ADDR_W];
        assign byp = wr_ok && wrt_addr == ra;
        assign rd_data[g*DATA_W +: DATA_W] = byp ? wrt_data : regs[ra];
        assign rd_busy[g] = busy[ra] & ~byp;
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scoreboard bench for reg_file_sb against an array-based reference model.
module tb_reg_file_sb;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] d;
        logic [1:0]  b;
        logic [4:0]  c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wrt_en = 1'b0;
    logic [3:0]  wrt_addr = '0;
    logic [31:0] wrt_data = '0;
    logic        issue_en = 1'b0;
    logic [3:0]  issue_addr = '0;
    logic [4:0]  busy_cnt;

    logic [31:0] m_regs [16];
    bit          m_busy [16];
    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;

    reg_file_sb dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wrt_en(wrt_en), .wrt_addr(wrt_addr), .wrt_data(wrt_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            tests += 3;
            if (rd_data !== e.d) begin
                fails++;
                $display("FAIL rd_data addr=%h got %h expected %h", rd_addr, rd_data, e.d);
            end
            if (rd_busy !== e.b) begin
                fails++;
                $display("FAIL rd_busy addr=%h got %b expected %b", rd_addr, rd_busy, e.b);
            end
            if (busy_cnt !== e.c) begin
                fails++;
                $display("FAIL busy_cnt got %0d expected %0d", busy_cnt, e.c);
            end
        end
    end

    function automatic exp_t expect_now();
        exp_t e;
        int n = 0;
        for (int p = 0; p < 2; p++) begin
            logic [3:0] ra = rd_addr[p*4 +: 4];
            bit byp = wrt_en && wrt_addr == ra && !(ZR && wrt_addr == 0);
            e.d[p*32 +: 32] = byp ? wrt_data : m_regs[ra];
            e.b[p] = m_busy[ra] && !byp;
        end
        for (int i = 0; i < 16; i++) n += int'(m_busy[i]);
        e.c = 5'(n);
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 0;
        end
    endtask

    // called at posedge+1; returns at next posedge+1 with the model advanced
    task automatic step(input bit we, input int wa, input logic [31:0] wd,
                        input bit ie, input int ia, input int r1, input int r0);
        wrt_en = we; wrt_addr = 4'(wa); wrt_data = wd;
        issue_en = ie; issue_addr = 4'(ia);
        rd_addr = {4'(r1), 4'(r0)};
        #1 q.push_back(expect_now());
        @(posedge clk);
        if (we && !(ZR && wa == 0)) begin
            m_regs[wa] = wd;
            m_busy[wa] = 0;
        end
        if (ie && !(ZR && ia == 0)) m_busy[ia] = 1;
        #1;
    endtask

    task automatic pulse_reset(input int r1, input int r0);
        wrt_en = 0; issue_en = 0;
        rd_addr = {4'(r1), 4'(r0)};
        rst = 0;
        model_reset();
        #1 q.push_back(expect_now());
        @(negedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        #2 q.push_back(expect_now());
        @(negedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1;
        for (int a = 0; a < 16; a++) step(0, 0, 0, 0, 0, a, a);
        step(1, 1, 5, 0, 0, 0, 0);
        step(1, 2, 3, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 2);
        step(1, 2, 32'hDEADBEEF, 0, 0, 1, 2);
        step(0, 0, 0, 1, 3, 3, 3);
        step(1, 3, 32'h11, 1, 3, 3, 3);
        step(1, 3, 32'h22, 0, 0, 3, 3);
        step(0, 0, 0, 0, 0, 3, 3);
        for (int a = 4; a < 8; a++) step(0, 0, 0, 1, a, 4, a);
        step(1, 4, 32'h55, 0, 0, 5, 4);
        pulse_reset(5, 4);
        step(0, 0, 0, 0, 0, 7, 4);
        step(1, 0, 32'h1234, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 32'h99, 0, 0, 0, 0);
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 59) == 0) pulse_reset($urandom_range(0, 15), $urandom_range(0, 15));
            else step($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom,
                      $urandom_range(0, 2) != 0, $urandom_range(0, 15),
                      $urandom_range(0, 15), $urandom_range(0, 15));
        end
        @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
